// File: rtl/rr_dispatch4.sv
// rr_dispatch4: 1-to-4 round-robin dispatcher.
// One valid/ready producer feeds four valid/ready consumer lanes. Each lane has
// a one-entry output register, so a stalled consumer only blocks its own lane.
// A circular pointer rotates the starting lane after every accepted item.
module rr_dispatch4 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [3:0]      lane_en,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic [1:0]      ptr
);

    logic [3:0]         available;
    logic [3:0]         cand;
    logic [1:0]         target;
    logic               accept;
    logic [3:0][DW-1:0] slot;

    // A lane can take an item if it is empty or its current item leaves this cycle.
    always_comb begin
        available = ~out_valid | out_ready;
        cand      = lane_en & available;
        in_ready  = |cand;
        accept    = in_valid & in_ready;
    end

    // Pick the first candidate lane, searching circularly upward from ptr.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        target = ptr;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && cand[idx]) begin
                found  = 1'b1;
                target = idx;
            end
        end
    end

    // Lane registers: refill takes priority over drain, so a same-cycle
    // drain+refill keeps the lane valid with the new item and no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 4'b0000;
            slot      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (target == i[1:0])) begin
                    out_valid[i] <= 1'b1;
                    slot[i]      <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Pointer moves past the lane just served; it holds on idle and drain-only cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (accept) begin
            ptr <= target + 2'd1;
        end
    end

    assign out_data = slot;

endmodule

// File: doc/rr_dispatch4.md
Name: rr_dispatch4

Overview:
- 1-to-4 round-robin dispatcher; counterpart of the 4-way round-robin arbiter (one producer fanned out to four consumers instead of four requesters merged to one).
- Accepts items on a single valid/ready input and distributes them fairly across four valid/ready output lanes.
- Each lane owns a one-entry output register, so a stalled consumer does not block the others.
- Sits in front of replicated workers (e.g. four pipeline engines) fed from one request stream.

Parameters:
- DW, 8, data width of one item.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an item.
- in_ready  output  1  dispatcher accepts the item this cycle.
- in_data  input  DW  item payload.
- lane_en  input  4  per-lane enable; a disabled lane is never selected as a target.
- out_valid  output  4  lane i holds an item.
- out_ready  input  4  consumer i takes the item.
- out_data  output  4*DW  lane i payload at bits [i*DW +: DW].
- ptr  output  2  current round-robin start lane (debug/status).

Behaviour:
- Reset (async assert, sync deassert at the flops): out_valid=4'b0000, out_data all zero, ptr=0.
- Lane slot i is available when out_valid[i]==0, or when out_valid[i]&out_ready[i] (draining this cycle).
- Candidate set: cand[i] = lane_en[i] & available[i].
- Target is the first set bit of cand, searching circularly from ptr upward: ptr, ptr+1, ... mod 4.
- in_ready = |cand, computed combinationally.
  - Depends on out_ready; no combinational path from in_valid to in_ready.
  - in_ready does not depend on in_valid.
- Accept = in_valid & in_ready. On accept, at the next edge:
  - slot[target] loads in_data;
  - out_valid[target]=1;
  - ptr = (target+1) mod 4, wrapping 3 to 0.
- No accept: ptr holds. Pointer never advances on idle cycles or on drains.
- Drain: out_valid[i]&out_ready[i] with lane i not the accept target → out_valid[i]=0 next cycle. out_data[i] holds its last value (don't-care when invalid).
- Simultaneous drain and refill of the same lane → out_valid[i] stays 1 and out_data[i] takes the new item. No bubble, no loss.
- Latency: accepted item appears on out_valid/out_data exactly 1 cycle after the accept edge.
- At most one item is accepted per cycle. Multiple lanes may drain in the same cycle.
- Output stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] must not change.
- lane_en:
  - Sampled combinationally, affects target selection only.
  - A disabled lane still holding data keeps out_valid=1 and drains normally.
  - lane_en=0000 → in_ready=0.
- All enabled lanes full and none draining → in_ready=0. Producer holds its item; nothing is dropped.
- Reset mid-operation: all pending lane items are discarded immediately (out_valid=0 asynchronously) and ptr returns to 0.
- Fairness: with all lanes enabled and always ready, items go to lanes 0,1,2,3,0,... in strict rotation. Any lane skipped because it was busy gets the next item once it frees, unless an earlier lane in circular order from ptr is also available.

Test Plan:
- Reset, lane_en=1111, out_ready=1111, stream 8 items 0x10..0x17 back-to-back → in_ready=1 every cycle; lanes receive 0x10→L0, 0x11→L1, 0x12→L2, 0x13→L3, 0x14→L0...; ptr sequence 1,2,3,0,1,2,3,0.
- out_ready=0000, push 5 items 0xA0..0xA4 → 0xA0..0xA3 land in L0..L3; in_ready=0 from the 5th cycle; 0xA4 is held. Then raise out_ready[2] only → 0xA4 accepted into L2 in the same cycle L2 drains; out_valid[2] stays 1 with data 0xA4.
- lane_en=1010, out_ready=1111, push 4 items → targets L1,L3,L1,L3; out_valid[0] and out_valid[2] stay 0 throughout.
- out_ready=1011 with L2 full, ptr=2, push 0x55 → target L3, ptr becomes 0; then out_ready=1111, push 0x66 → target L0.
- Fill L0 and L1 with 0x11 and 0x22 (ready low), assert rst_n=0 for one cycle mid-stream → out_valid=0000 immediately, ptr=0; first push after release lands in L0.
- lane_en=0000 with in_valid=1 for 10 cycles → in_ready=0 for all 10 cycles, out_valid unchanged.
